// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_add_row.sv
// Ripple-carry adder built from a chain of full-adder cells; carry-out is dropped
// because the accumulator arithmetic is modulo 2^W.
module mul_add_row #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

endmodule

// File: rtl/pipe_seq_multiplier.sv
// Sequential sign-magnitude multiplier: one partial product per cycle through a
// shared ripple adder, with a valid/ready handshake on both sides.
module pipe_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [PW-1:0]    acc;
  logic             neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic             sign_mode;
  logic             accept;

  // Magnitude of a possibly-negative operand; the most negative value maps to
  // 2^(WIDTH-1), which still fits the unsigned WIDTH-bit result.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (sgn && v[WIDTH-1]) ? n : v;
  endfunction

  // Two's-complement negation modulo 2^(2*WIDTH); zero stays zero.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic ng);
    return ng ? (~v + 1'b1) : v;
  endfunction

  assign sign_mode = (SIGNED_EN != 0) && in_signed;
  assign accept    = in_valid && in_ready;

  // Partial product for the current bit of the multiplier magnitude.
  always_comb begin
    addend = '0;
    if (mag_b[count]) addend = {{WIDTH{1'b0}}, mag_a} << count;
  end

  mul_add_row #(.W(PW)) u_add (
    .a   (acc),
    .b   (addend),
    .sum (sum)
  );

  // Operand magnitude registers: data only, loaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_a <= magnitude(in_a, sign_mode);
      mag_b <= magnitude(in_b, sign_mode);
    end
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      out_p     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            state    <= RUN;
            count    <= '0;
            acc      <= '0;
            neg      <= sign_mode && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc   <= sum;
          count <= count + 1'b1;
          if (count == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_p     <= apply_sign(sum, neg);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
